// File: rtl/faddsub_pipe_if.sv
// rtl/faddsub_pipe_if.sv - operand/result handshake bundle for faddsub_pipe
interface faddsub_pipe_if #(
   parameter int EW = 8,
   parameter int MW = 23
);
   localparam int W = 1 + EW + MW;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x1;
   logic [W-1:0] x2;
   logic         op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         ovf;

   modport master (
      output in_valid, x1, x2, op, out_ready,
      input  in_ready, out_valid, y, ovf
   );

   modport slave (
      input  in_valid, x1, x2, op, out_ready,
      output in_ready, out_valid, y, ovf
   );
endinterface

// File: rtl/faddsub_pipe.sv
// rtl/faddsub_pipe.sv - 3-stage floating-point add/subtract (align, add/normalise, round/special)
module faddsub_pipe #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic          clk,
   input  logic          rst,
   faddsub_pipe_if.slave bus
);
   localparam int W  = 1 + EW + MW;
   localparam int NW = MW + 4;   // hidden bit, fraction, guard, round, sticky
   localparam int SW = $clog2(NW);

   logic stall;
   assign stall        = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall;

   // ---------------- S1: classify, order by magnitude, align ----------------
   logic          sa, sb, a_nan, b_nan, a_inf, b_inf, a_big, sp;
   logic [EW-1:0] ea, eb, ea_eff, eb_eff, el, es;
   logic [MW:0]   ma, mb, ml, ms;
   logic [NW-1:0] ext, mask, shifted, al;
   logic [SW-1:0] shamt;
   logic [31:0]   diff;
   logic [W-1:0]  spy;

   always_comb begin
      sa     = bus.x1[W-1];
      sb     = bus.x2[W-1] ^ bus.op;
      ea     = bus.x1[W-2:MW];
      eb     = bus.x2[W-2:MW];
      a_nan  = (&ea) && (|bus.x1[MW-1:0]);
      b_nan  = (&eb) && (|bus.x2[MW-1:0]);
      a_inf  = (&ea) && !(|bus.x1[MW-1:0]);
      b_inf  = (&eb) && !(|bus.x2[MW-1:0]);
      ea_eff = (ea == '0) ? EW'(1) : ea;
      eb_eff = (eb == '0) ? EW'(1) : eb;
      ma     = {|ea, bus.x1[MW-1:0]};
      mb     = {|eb, bus.x2[MW-1:0]};
      a_big  = {ea_eff, ma} >= {eb_eff, mb};
      el     = a_big ? ea_eff : eb_eff;
      es     = a_big ? eb_eff : ea_eff;
      ml     = a_big ? ma : mb;
      ms     = a_big ? mb : ma;
      diff   = 32'(el) - 32'(es);
      shamt  = (diff >= 32'(MW + 3)) ? SW'(MW + 3) : SW'(diff);
      ext     = {ms, 3'b000};
      mask    = ~({NW{1'b1}} << shamt);
      shifted = ext >> shamt;
      al      = {shifted[NW-1:1], shifted[0] | (|(ext & mask))};
      // NaN/infinity outcome is resolved here and carried alongside the datapath
      sp  = a_nan | b_nan | a_inf | b_inf;
      spy = '0;
      if (a_nan && b_nan)
         spy = {sb, {EW{1'b1}}, 1'b1, bus.x2[MW-2:0]};
      else if (a_nan)
         spy = {sa, {EW{1'b1}}, 1'b1, bus.x1[MW-2:0]};
      else if (b_nan)
         spy = {sb, {EW{1'b1}}, 1'b1, bus.x2[MW-2:0]};
      else if (a_inf && b_inf)
         spy = (sa == sb) ? {sa, {EW{1'b1}}, {MW{1'b0}}}
                          : {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      else if (a_inf)
         spy = {sa, {EW{1'b1}}, {MW{1'b0}}};
      else if (b_inf)
         spy = {sb, {EW{1'b1}}, {MW{1'b0}}};
   end

   logic          v1, s1_sign, s1_sub, s1_zs, s1_sp;
   logic [EW-1:0] s1_exp;
   logic [NW-1:0] s1_ml, s1_ms;
   logic [W-1:0]  s1_spy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_sub  <= 1'b0;
         s1_zs   <= 1'b0;
         s1_sp   <= 1'b0;
         s1_exp  <= '0;
         s1_ml   <= '0;
         s1_ms   <= '0;
         s1_spy  <= '0;
      end else if (!stall) begin
         v1      <= bus.in_valid;
         s1_sign <= a_big ? sa : sb;
         s1_sub  <= sa ^ sb;
         s1_zs   <= sa & sb;
         s1_sp   <= sp;
         s1_exp  <= el;
         s1_ml   <= {ml, 3'b000};
         s1_ms   <= al;
         s1_spy  <= spy;
      end
   end

   // ---------------- S2: add, normalise ----------------
   logic [NW:0]   sum;
   logic [NW-1:0] nm;
   logic [EW:0]   ne;
   int            msb, sh;

   always_comb begin
      sum = s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});
      msb = 0;
      for (int i = 0; i < NW; i++)
         if (sum[i]) msb = i;
      sh = 0;
      nm = sum[NW-1:0];
      ne = {1'b0, s1_exp};
      if (sum[NW]) begin
         nm = {sum[NW:2], sum[1] | sum[0]};
         ne = ne + (EW+1)'(1);
      end else begin
         // left shift stops at exponent 1; anything still unnormalised is subnormal
         sh = NW - 1 - msb;
         if (sh > int'(s1_exp) - 1)
            sh = int'(s1_exp) - 1;
         nm = sum[NW-1:0] << sh;
         ne = ne - (EW+1)'(sh);
         if (!nm[NW-1])
            ne = '0;
      end
   end

   logic          v2, s2_sign, s2_zero, s2_zs, s2_sp;
   logic [EW:0]   s2_exp;
   logic [NW-2:0] s2_m;
   logic [W-1:0]  s2_spy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_zs   <= 1'b0;
         s2_sp   <= 1'b0;
         s2_exp  <= '0;
         s2_m    <= '0;
         s2_spy  <= '0;
      end else if (!stall) begin
         v2      <= v1;
         s2_sign <= s1_sign;
         s2_zero <= (sum == '0);
         s2_zs   <= s1_zs;
         s2_sp   <= s1_sp;
         s2_exp  <= ne;
         s2_m    <= nm[NW-2:0];
         s2_spy  <= s1_spy;
      end
   end

   // ---------------- S3: round to nearest even, special/overflow select ----------------
   logic              rup, novf;
   logic [EW+MW:0]    res;
   logic [W-1:0]      ny;

   always_comb begin
      rup  = s2_m[2] & (s2_m[1] | s2_m[0] | s2_m[3]);
      // carry out of the fraction rolls into the exponent field naturally
      res  = {s2_exp, s2_m[NW-2:3]} + (EW+MW+1)'(rup);
      ny   = {s2_sign, res[EW+MW-1:0]};
      novf = 1'b0;
      if (s2_sp)
         ny = s2_spy;
      else if (s2_zero)
         ny = {s2_zs, {(W-1){1'b0}}};
      else if (res[EW+MW:MW] >= {1'b0, {EW{1'b1}}}) begin
         ny   = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
         novf = 1'b1;
      end
   end

   logic         v3, ovf_q;
   logic [W-1:0] y_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3    <= 1'b0;
         y_q   <= '0;
         ovf_q <= 1'b0;
      end else if (!stall) begin
         v3    <= v2;
         y_q   <= ny;
         ovf_q <= novf;
      end
   end

   assign bus.out_valid = v3;
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_faddsub_pipe.sv
// tb/tb_faddsub_pipe.sv - scoreboard bench for faddsub_pipe (EW=8, MW=23)
module tb_faddsub_pipe;
   localparam int EW = 8;
   localparam int MW = 23;
   localparam int W  = 32;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic [W-1:0] y;
      logic         ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   faddsub_pipe_if #(.EW(EW), .MW(MW)) bus ();
   faddsub_pipe #(.EW(EW), .MW(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int           n_cmp   = 0;
   int           n_err   = 0;
   int           n_deliv = 0;
   logic [W:0]   sb_q[$];
   logic [W:0]   mon_exp;

   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_cmp++;
         n_deliv++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected got y=%h ovf=%b, required no output", bus.y, bus.ovf);
         end else begin
            mon_exp = sb_q.pop_front();
            if ({bus.y, bus.ovf} !== mon_exp) begin
               n_err++;
               $display("FAIL sb_result got y=%h ovf=%b, required y=%h ovf=%b",
                        bus.y, bus.ovf, mon_exp[W:1], mon_exp[0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                       input logic [W-1:0] ey, input logic eo);
      bus.x1 = a;
      bus.x2 = b;
      bus.op = o;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb_q.push_back({ey, eo});
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout in_ready=0, required 1 within 40 cycles");
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !bus.out_valid) break;
      end
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d, required 0", sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.x1 = '0;
      bus.x2 = '0;
      bus.op = 1'b0;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b, required 0", bus.out_valid); end
      n_cmp++;
      if (bus.y !== 32'h0) begin n_err++; $display("FAIL rst_y got %h, required 00000000", bus.y); end
      n_cmp++;
      if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b, required 0", bus.ovf); end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b, required 1", bus.in_ready); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_latency();
      bus.out_ready = 1'b1;
      bus.x1 = 32'h40400000;
      bus.x2 = 32'h3F800000;
      bus.op = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready got %b, required 1", bus.in_ready); end
      sb_q.push_back({32'h40000000, 1'b0});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.out_valid !== (e == 3)) begin
            n_err++;
            $display("FAIL lat_edge%0d out_valid got %b, required %b", e, bus.out_valid, (e == 3));
         end
         if (e < 3) begin
            @(posedge clk);
            #1;
         end
      end
      drain();
   endtask

   task automatic test_arith();
      vec_t v[13];
      v = '{
         '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0},
         '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0},
         '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1},
         '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0},
         '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0},
         '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0},
         '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0},
         '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0},
         '{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 1'b0},
         '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0},
         '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 32'hFF800000, 1'b1},
         '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0}
      };
      bus.out_ready = 1'b1;
      foreach (v[i]) send(v[i].a, v[i].b, v[i].op, v[i].y, v[i].ovf);
      drain();
   endtask

   task automatic test_special();
      vec_t v[10];
      v = '{
         '{32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 1'b0},
         '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00001, 1'b0},
         '{32'h7F800001, 32'h7F7FFFFF, 1'b1, 32'h7FC00001, 1'b0},
         '{32'h7F800001, 32'hFF800002, 1'b1, 32'h7FC00002, 1'b0},
         '{32'h3F800000, 32'hFF800005, 1'b1, 32'h7FC00005, 1'b0},
         '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0},
         '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0},
         '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0},
         '{32'h7F7FFFFF, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0},
         '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0}
      };
      bus.out_ready = 1'b1;
      foreach (v[i]) send(v[i].a, v[i].b, v[i].op, v[i].y, v[i].ovf);
      drain();
   endtask

   task automatic test_back_to_back();
      int           d0;
      logic         seen;
      logic [W-1:0] cap;
      d0 = n_deliv;
      seen = 1'b0;
      cap = '0;
      bus.out_ready = 1'b1;
      fork
         begin
            send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
            send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
            send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
            send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0);
            send(32'h40800000, 32'h3F800000, 1'b0, 32'h40A00000, 1'b0);
         end
         begin
            for (int i = 0; i < 30 && !seen; i++) begin
               @(negedge clk);
               if (bus.out_valid) seen = 1'b1;
            end
            n_cmp++;
            if (!seen) begin n_err++; $display("FAIL b2b_first_out out_valid got 0, required 1"); end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (k == 0) cap = bus.y;
               n_cmp++;
               if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall%0d in_ready got %b, required 0", k, bus.in_ready); end
               n_cmp++;
               if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_stall%0d out_valid got %b, required 1", k, bus.out_valid); end
               if (k > 0) begin
                  n_cmp++;
                  if (bus.y !== cap) begin n_err++; $display("FAIL b2b_stall%0d y got %h, required stable %h", k, bus.y, cap); end
               end
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      n_cmp++;
      if (n_deliv - d0 != 5) begin n_err++; $display("FAIL b2b_count delivered %0d, required 5", n_deliv - d0); end
   endtask

   task automatic test_reset_inflight();
      int d0;
      d0 = n_deliv;
      bus.out_ready = 1'b0;
      send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0);
      send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rsf_pre out_valid got %b, required 1", bus.out_valid); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rsf_out_valid got %b, required 0", bus.out_valid); end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rsf_in_ready got %b, required 1", bus.in_ready); end
      n_cmp++;
      if (bus.y !== 32'h0) begin n_err++; $display("FAIL rsf_y got %h, required 00000000", bus.y); end
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (n_deliv != d0) begin n_err++; $display("FAIL rsf_no_emit delivered %0d, required 0", n_deliv - d0); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_arith();
      test_special();
      test_back_to_back();
      test_reset_inflight();
      test_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/faddsub_pipe.md
FADDSUB_PIPE -- requirements
Module: faddsub_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width in bits (valid range 4..11).
REQ-002 SHALL have parameter MW, default 23, stored fraction width in bits (valid range 4..52).
REQ-003 SHALL define W = 1+EW+MW as the operand and result width.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 rst  input  1  Reset, asynchronous and active-high.
REQ-006 in_valid  input  1  Operand set on x1/x2/op is valid this cycle.
REQ-007 in_ready  output  1  Block accepts an operand set this cycle.
REQ-008 x1  input  W  Operand A, IEEE-754 style {sign, exponent, fraction}.
REQ-009 x2  input  W  Operand B, same format.
REQ-010 op  input  1  0 = x1+x2, 1 = x1-x2.
REQ-011 out_valid  output  1  y/ovf hold a valid result.
REQ-012 out_ready  input  1  Consumer takes the result this cycle.
REQ-013 y  output  W  Result.
REQ-014 ovf  output  1  Finite operands rounded to an infinite result.

Function
REQ-015 SHALL implement a 3-stage pipeline (S1 align, S2 add/normalise, S3 round/special) with a valid bit per stage.
REQ-016 Latency SHALL be exactly 3 clk edges from the input handshake (in_valid && in_ready) to out_valid when out_ready is held high.
REQ-017 Throughput SHALL be one operation per cycle without backpressure.
REQ-018 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-019 When out_valid && !out_ready, all stages SHALL hold, and y/ovf SHALL remain stable until the handshake completes.
REQ-020 Bubbles SHALL propagate, and a stage SHALL load whenever the pipeline is not stalled.
REQ-021 Subtraction SHALL invert the sign of x2 before alignment; every later step treats the operation as addition.
REQ-022 Subnormal inputs SHALL use an effective exponent of 1 and no hidden bit.
REQ-023 The datapath SHALL retain guard and round bits plus a sticky OR of all bits shifted out.
REQ-024 Any alignment shift of MW+3 or more SHALL saturate to that value.
REQ-025 Rounding SHALL be round-to-nearest-even.
REQ-026 Mantissa carry-out after rounding SHALL increment the exponent.
REQ-027 Results below the normal range SHALL be emitted as subnormal, and a zero result SHALL be emitted with exponent 0.
REQ-028 An exact zero sum SHALL be +0, except (-0)+(-0), which SHALL be -0.
REQ-029 A finite result with exponent at or above 2^EW-1 SHALL give y = ±infinity with sign equal to the result sign, and SHALL set ovf=1.
REQ-030 ovf SHALL be 0 whenever either operand is infinity or NaN.
REQ-031 If one operand is NaN, y SHALL be that NaN with the fraction MSB forced to 1.
REQ-032 If both operands are NaN, y SHALL be the effective x2 NaN with the fraction MSB forced to 1.
REQ-033 Infinity plus finite SHALL give that infinity.
REQ-034 Infinities of equal effective sign SHALL give that infinity.
REQ-035 Infinities of opposite effective sign SHALL give the default NaN {1, all-ones, 1, zeros} with ovf=0.
REQ-036 The effective sign of x2 (after REQ-021) SHALL be used for special-case outputs.

Reset
REQ-037 While rst=1, all stage valid bits, out_valid and ovf SHALL be 0 and y SHALL be all zeros, asynchronously.
REQ-038 in_ready SHALL be 1 while rst=1.
REQ-039 Operations in flight when rst asserts SHALL be discarded and never emitted.
REQ-040 The first accepted operand after rst deasserts SHALL emit 3 cycles later.

Verification (EW=8, MW=23)
REQ-041 Bench SHALL drive x1=0x40400000, x2=0x3F800000, op=1 and require y=0x40000000 with ovf=0 on the third edge after acceptance.
REQ-042 Bench SHALL drive x1=0x3F800000, x2=0x3F800000, op=1 and require y=0x00000000; with x1=x2=0x80000000, op=0 it SHALL require y=0x80000000.
REQ-043 Bench SHALL drive x1=x2=0x7F7FFFFF, op=0 and require y=0x7F800000 with ovf=1.
REQ-044 Bench SHALL drive x1=x2=0x7F800000, op=1 and require y=0xFFC00000 with ovf=0; with x1=0x7F800001 and any finite x2 it SHALL require y=0x7FC00001.
REQ-045 Bench SHALL drive x1=0x00000001, x2=0x00000001, op=0 and require y=0x00000002, and SHALL drive x1=0x3F800000, x2=0x33800000, op=0 and require y=0x3F800000 (tie rounds to even).
REQ-046 Bench SHALL stream 5 back-to-back operations, hold out_ready=0 for 4 cycles, and require in_ready=0, y stable and all 5 results delivered in order with none lost or duplicated.
REQ-047 Bench SHALL assert rst with 2 operations in flight and require out_valid=0 immediately, with neither result ever appearing afterwards.
